// File: rtl/of_stage_if.sv
// Operand-fetch stage bus: fetch handshake, decode flags, writeback port and registered operand outputs.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready toward fetch, out_valid/ex_ready toward execute.
interface of_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            is_imm;
  logic            is_st;
  logic            is_ret;
  logic            writes_rd;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_ready;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] immx;
  logic [XLEN-1:0] branch_target;
  logic [AW-1:0]   rd;
  logic [5:0]      opcode;
  logic            stop;
  logic            halted;

  // Environment side: fetch, writeback and execute.
  modport master (
    output in_valid, inst, pc, is_imm, is_st, is_ret, writes_rd,
    output wb_en, wb_addr, wb_data, ex_ready, flush,
    input  in_ready, out_valid, op1, op2, a, b, immx, branch_target,
    input  rd, opcode, stop, halted
  );

  // Stage side.
  modport slave (
    input  in_valid, inst, pc, is_imm, is_st, is_ret, writes_rd,
    input  wb_en, wb_addr, wb_data, ex_ready, flush,
    output in_ready, out_valid, op1, op2, a, b, immx, branch_target,
    output rd, opcode, stop, halted
  );
endinterface

// File: rtl/of_stage.sv
// Operand fetch: register read with writeback bypass, busy-bit scoreboard, immediate/branch target, halt detect.
// Latency: one cycle from accept to out_valid.
// Backpressure: entry holds while ex_ready=0; in_ready drops on hazard, flush, HALT or a stalled entry.
module of_stage #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int RA_REG   = NREGS - 1,
  parameter int ZERO_REG = 0
) (
  input  logic      clk,
  input  logic      reset,
  of_stage_if.slave bus
);
  localparam int            AW = $clog2(NREGS);
  localparam logic [AW-1:0] RA = AW'(RA_REG);
  localparam bit            ZR = (ZERO_REG != 0);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] rf [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;

  logic [AW-1:0]   rp1, rp2, rd_f;
  logic [XLEN-1:0] rv1, rv2, immx_f, bt_f;
  logic            busy1, busy2, hazard, accept, halt_inst, setb_f;

  logic            out_valid_q, stop_q, setb_q;
  logic [XLEN-1:0] op1_q, op2_q, b_q, immx_q, bt_q;
  logic [AW-1:0]   rd_q;
  logic [5:0]      opcode_q;

  // Decode register selects, immediate and branch target from the instruction word.
  always_comb begin
    rp1       = bus.is_ret ? RA : bus.inst[16 +: AW];
    rp2       = bus.is_st ? bus.inst[21 +: AW] : bus.inst[11 +: AW];
    rd_f      = bus.inst[21 +: AW];
    immx_f    = {{(XLEN-16){bus.inst[15]}}, bus.inst[15:0]};
    bt_f      = bus.pc + {{(XLEN-27){bus.inst[26]}}, bus.inst[26:0]};
    halt_inst = (bus.inst[31:27] == 5'b11111);
    // Register 0 under ZERO_REG never becomes busy, so it needs no release.
    setb_f    = bus.writes_rd && !(ZR && rd_f == '0);
  end

  // Register read with same-cycle writeback bypass; hardwired zero wins.
  always_comb begin
    rv1 = rf[rp1];
    rv2 = rf[rp2];
    if (bus.wb_en && bus.wb_addr == rp1) rv1 = bus.wb_data;
    if (bus.wb_en && bus.wb_addr == rp2) rv2 = bus.wb_data;
    if (ZR && rp1 == '0) rv1 = '0;
    if (ZR && rp2 == '0) rv2 = '0;
  end

  // Hazard check: a busy bit being released by this cycle's writeback does not stall.
  always_comb begin
    busy1  = busy[rp1] && !(bus.wb_en && bus.wb_addr == rp1);
    busy2  = busy[rp2] && !(bus.wb_en && bus.wb_addr == rp2);
    hazard = busy1 || busy2;
  end

  assign bus.in_ready = (state == RUN) && !hazard && !bus.flush && (!out_valid_q || bus.ex_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Scoreboard update: writeback and squash release, accept sets last so set wins.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_en) busy_nxt[bus.wb_addr] = 1'b0;
    if (bus.flush && out_valid_q && setb_q) busy_nxt[rd_q] = 1'b0;
    if (accept && setb_f) busy_nxt[rd_f] = 1'b1;
    if (ZR) busy_nxt[0] = 1'b0;
  end

  // Busy-bit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Register file write port; register 0 is read-only under ZERO_REG.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.wb_en && !(ZR && bus.wb_addr == '0)) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state: a halt instruction accepted in RUN parks the stage until reset.
  always_comb begin
    state_nxt = state;
    if (state == RUN && accept && halt_inst) state_nxt = HALT;
  end

  // Output entry: load on accept, drop valid on drain or squash, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      b_q         <= '0;
      immx_q      <= '0;
      bt_q        <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      stop_q      <= 1'b0;
      setb_q      <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op1_q       <= rv1;
      op2_q       <= rv2;
      b_q         <= bus.is_imm ? immx_f : rv2;
      immx_q      <= immx_f;
      bt_q        <= bt_f;
      rd_q        <= rd_f;
      opcode_q    <= bus.inst[31:26];
      stop_q      <= halt_inst;
      setb_q      <= setb_f;
    end else if (bus.flush || bus.ex_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.op1           = op1_q;
  assign bus.op2           = op2_q;
  assign bus.a             = op1_q;
  assign bus.b             = b_q;
  assign bus.immx          = immx_q;
  assign bus.branch_target = bt_q;
  assign bus.rd            = rd_q;
  assign bus.opcode        = opcode_q;
  assign bus.stop          = stop_q;
  assign bus.halted        = (state == HALT);
endmodule
